// File: rtl/bias3_grad.sv
// ============================================================================
//  Module      : bias3_grad
//  Description : Output-layer bias-gradient stage. Accumulates four Q8.8 TD
//                errors over a mini-batch of BATCH samples, scales the sums by
//                2^-(LR_SHIFT + log2(BATCH)), saturates to 16 bits and presents
//                the deltas to the layer-3 bias bank with a one-cycle strobe.
//                Optional feature macro: BIAS3_GRAD_CLIP_EN (clamp each delta
//                to [-CLIP, +CLIP] and expose a sticky clip_flag).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bias3_grad #(
    parameter int BATCH    = 4,
    parameter int LR_SHIFT = 4,
    parameter int CLIP     = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               err_valid,
    output logic               err_ready,
    input  logic signed [15:0] err1,
    input  logic signed [15:0] err2,
    input  logic signed [15:0] err3,
    input  logic signed [15:0] err4,
    output logic signed [15:0] deltab3_1,
    output logic signed [15:0] deltab3_2,
    output logic signed [15:0] deltab3_3,
    output logic signed [15:0] deltab3_4,
    output logic               upd_valid,
    output logic               busy,
    output logic [3:0]         sample_cnt
`ifdef BIAS3_GRAD_CLIP_EN
    ,
    output logic               clip_flag
`endif
);

    localparam int C_BLOG  = $clog2(BATCH);
    localparam int ACCW    = 16 + C_BLOG;
    localparam int C_SHIFT = LR_SHIFT + C_BLOG;
`ifdef BIAS3_GRAD_CLIP_EN
    localparam bit C_CLIP_EN = 1'b1;
`else
    localparam bit C_CLIP_EN = 1'b0;
`endif
    localparam logic signed [31:0] C_CLIP  = 32'(CLIP);
    localparam logic signed [31:0] C_NCLIP = -C_CLIP;
    localparam logic [4:0]         C_BATCH = 5'(BATCH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_SCALE = 2'd2,
        S_APPLY = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic signed [ACCW-1:0]  r_acc   [4];
    logic signed [15:0]      r_delta [4];
    logic signed [15:0]      w_err   [4];
    logic signed [15:0]      w_delta [4];
    logic        [3:0]       w_clamp;
    logic [4:0]              r_cnt;
    logic [4:0]              w_cnt_nxt;
    logic                    w_accept;
    logic                    w_last;

    assign w_err[0] = err1;
    assign w_err[1] = err2;
    assign w_err[2] = err3;
    assign w_err[3] = err4;

    assign deltab3_1  = r_delta[0];
    assign deltab3_2  = r_delta[1];
    assign deltab3_3  = r_delta[2];
    assign deltab3_4  = r_delta[3];
    assign sample_cnt = r_cnt[3:0];

    // The counter is one bit wider than sample_cnt so BATCH=16 can be detected.
    assign w_cnt_nxt = r_cnt + 5'd1;
    assign w_accept  = err_valid && err_ready;
    assign w_last    = (w_cnt_nxt == C_BATCH);

    // Per-lane scale, 16-bit saturation and optional clamp.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic signed [ACCW-1:0] w_sh;
        logic signed [31:0]     w_wide;
        logic signed [31:0]     w_sat;
        logic                   w_hi;
        logic                   w_lo;

        assign w_sh   = r_acc[g] >>> C_SHIFT;
        assign w_wide = 32'(w_sh);

        // Saturator is unreachable for legal parameters but guards against misuse.
        always_comb begin
            w_sat = w_wide;
            if (w_wide > 32'sd32767) begin
                w_sat = 32'sd32767;
            end else if (w_wide < -32'sd32768) begin
                w_sat = -32'sd32768;
            end
        end

        assign w_hi       = C_CLIP_EN && (w_sat > C_CLIP);
        assign w_lo       = C_CLIP_EN && (w_sat < C_NCLIP);
        assign w_clamp[g] = w_hi || w_lo;
        assign w_delta[g] = w_hi ? C_CLIP[15:0] : (w_lo ? C_NCLIP[15:0] : w_sat[15:0]);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        w_state_nxt = r_state;
        err_ready   = 1'b0;
        busy        = 1'b0;
        upd_valid   = 1'b0;
        case (r_state)
            S_IDLE, S_ACCUM: begin
                err_ready = 1'b1;
                if (err_valid) begin
                    w_state_nxt = w_last ? S_SCALE : S_ACCUM;
                end
            end
            S_SCALE: begin
                busy        = 1'b1;
                w_state_nxt = S_APPLY;
            end
            S_APPLY: begin
                busy        = 1'b1;
                upd_valid   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Accumulators, sample counter and delta registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 5'd0;
            for (int i = 0; i < 4; i++) begin
                r_acc[i]   <= '0;
                r_delta[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= 5'd1;
                        for (int i = 0; i < 4; i++) begin
                            r_acc[i] <= ACCW'(w_err[i]);
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_cnt <= w_cnt_nxt;
                        for (int i = 0; i < 4; i++) begin
                            r_acc[i] <= r_acc[i] + ACCW'(w_err[i]);
                        end
                    end
                end
                S_SCALE: begin
                    // Sums are consumed here, so the batch state can clear now.
                    r_cnt <= 5'd0;
                    for (int i = 0; i < 4; i++) begin
                        r_delta[i] <= w_delta[i];
                        r_acc[i]   <= '0;
                    end
                end
                default: begin
                    // Zero deltas outside APPLY so a stray bank update adds nothing.
                    for (int i = 0; i < 4; i++) begin
                        r_delta[i] <= '0;
                    end
                end
            endcase
        end
    end

`ifdef BIAS3_GRAD_CLIP_EN
    // Sticky flag: set on any clamp during SCALE, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            clip_flag <= 1'b0;
        end else if (r_state == S_SCALE && (|w_clamp)) begin
            clip_flag <= 1'b1;
        end
    end
`else
    logic w_unused_clamp;
    assign w_unused_clamp = |w_clamp;
`endif

endmodule

`default_nettype wire

// File: doc/bias3_grad.md
Name: bias3_grad

Overview:
- Output-layer bias-gradient stage for the DQN training datapath.
- Sits directly upstream of the layer-3 bias register bank and produces its four signed 16-bit bias deltas.
- Accumulates per-neuron TD errors (Q_target − Q_pred, Q8.8) over a mini-batch and scales the sum by batch size and learning rate.
- Presents the deltas with a one-cycle update strobe, timed to the layer-3 update phase (ctrl = 4'b0011).

Parameters:
- BATCH, 4, samples per mini-batch; power of two, 1..16.
- LR_SHIFT, 4, learning rate = 2^-LR_SHIFT; range 0..11.
- CLIP, 256, magnitude limit applied to each delta when BIAS3_GRAD_CLIP_EN is defined (Q8.8, 1..32767).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- err_valid  in  1  err1..err4 carry a valid sample this cycle.
- err_ready  out  1  block accepts a sample this cycle.
- err1, err2, err3, err4  in  16 signed  output-neuron TD errors, Q8.8.
- deltab3_1, deltab3_2, deltab3_3, deltab3_4  out  16 signed  bias deltas, Q8.8.
- upd_valid  out  1  one-cycle strobe; deltas valid, bias bank adds them this cycle.
- busy  out  1  high in SCALE and APPLY.
- sample_cnt  out  4  samples accumulated in the current batch.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset sets state=IDLE, all accumulators=0, sample_cnt=0, deltab3_*=0, upd_valid=0, busy=0, err_ready=1. Reset has priority over every other input.
- A sample is accepted on a rising edge where err_valid && err_ready.
- Accumulators: four signed registers, width ACCW = 16 + log2(BATCH). Each is acc_i += sign-extended err_i. No overflow is possible by construction.
- IDLE: err_ready=1. An accepted sample loads acc_i = err_i, sets sample_cnt=1 and goes to ACCUM. With BATCH=1 it goes directly to SCALE.
- ACCUM: err_ready=1. Each accepted sample adds to the accumulators and increments sample_cnt. The BATCH-th accepted sample goes to SCALE.
- SCALE (1 cycle): err_ready=0, busy=1.
  - deltab3_i <= acc_i >>> (LR_SHIFT + log2(BATCH)), arithmetic shift, truncation toward −inf.
  - Result is saturated to [−32768, 32767]; it cannot exceed that range for legal parameters, but the saturator is kept.
  - Clipping is applied afterwards if the optional feature is enabled.
  - Next state: APPLY.
- APPLY (1 cycle): err_ready=0, busy=1, upd_valid=1, deltas stable. Accumulators and sample_cnt clear. Next state: IDLE.
- After APPLY, deltab3_* return to 0 and stay 0 until the next SCALE, so a stray bias-bank update adds nothing.
- err_valid during SCALE/APPLY is ignored. The source holds the sample until err_ready=1.
- Total latency: BATCH-th sample accepted at edge N → upd_valid high during the cycle after edge N+1.
- Back-to-back: the next batch's first sample is accepted the cycle after APPLY, with no bubble beyond SCALE/APPLY.
- Reset mid-batch (ACCUM, SCALE or APPLY) discards the partial batch and produces no upd_valid.
- sign convention: positive error → positive delta; the bias bank adds the delta (gradient descent on squared TD error).

Optional Feature:
- Macro: BIAS3_GRAD_CLIP_EN.
- Defined: after scaling, each delta is clamped to [−CLIP, +CLIP]. A sticky output clip_flag (1 bit, reset 0) sets on any clamp and clears only on rst.
- Undefined: no clamp, no clip_flag port; deltas equal the saturated scaled value.

Test Plan (BATCH=4, LR_SHIFT=4 unless stated):
- Four samples, all err=16 → acc=64, deltab3_1..4=1; upd_valid high exactly one cycle, 2 cycles after the 4th sample edge; deltas 0 the cycle after.
- Four samples of err1=−16, err2=32, err3=0, err4=−1 → deltas −1, 2, 0, −1 (−4>>>6 truncates to −1).
- err_valid held high continuously for 10 samples → exactly two upd_valid strobes; samples 9–10 leave sample_cnt=2; err_ready low during both SCALE/APPLY windows, and samples offered there are not counted.
- rst asserted after 3 samples, then 4 samples of err=160 → no strobe for the aborted batch; next strobe delivers deltas=10.
- BATCH=1, LR_SHIFT=0, err=32767/−32768 → deltas 32767/−32768, no wrap; with BIAS3_GRAD_CLIP_EN and CLIP=256 → 256/−256 and clip_flag=1.
- LR_SHIFT=11, BATCH=16, all err=1 → deltas 0 (underflow to zero), upd_valid still pulses.
